vga_timing_gen: RTL and testbench

//  Generates 640x480@60Hz VGA raster timing: hCount/vCount, bright, active-low hSync/vSync.

---
 rtl/vga_timing_gen_if.sv | 19 +
 rtl/vga_timing_gen.sv | 92 +++++++++
 tb/tb_vga_timing_gen.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the VGA timing generator to the pixel painter and connector.
// The master drives every signal; the slave only observes.
interface vga_timing_gen_if;
  logic [9:0] hCount;
  logic [9:0] vCount;
  logic       bright;
  logic       hSync;
  logic       vSync;
  logic       pix_en;
  logic       frame_tick;

  modport master (
    output hCount, vCount, bright, hSync, vSync, pix_en, frame_tick
  );

  modport slave (
    input hCount, vCount, bright, hSync, vSync, pix_en, frame_tick
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60Hz raster generator (sync-first origin) with a pixel-rate strobe and a frame strobe.
// All outputs are registered; syncs and bright are decoded from next counter values for zero skew.
module vga_timing_gen #(
  parameter int CLK_DIV     = 4,
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_VIS_START = 144,
  parameter int H_VIS_END   = 784,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_VIS_START = 35,
  parameter int V_VIS_END   = 515
) (
  input  logic             clk,
  input  logic             reset_n,
  vga_timing_gen_if.master o_vga
);
  localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]      H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]      V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]      H_SW     = 10'(H_SYNC);
  localparam logic [9:0]      V_SW     = 10'(V_SYNC);
  localparam logic [9:0]      H_VS     = 10'(H_VIS_START);
  localparam logic [9:0]      H_VE     = 10'(H_VIS_END);
  localparam logic [9:0]      V_VS     = 10'(V_VIS_START);
  localparam logic [9:0]      V_VE     = 10'(V_VIS_END);

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_nxt;
  logic [9:0]       r_h;
  logic [9:0]       r_v;
  logic [9:0]       w_h_nxt;
  logic [9:0]       w_v_nxt;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_bright;
  logic             r_pix_en;
  logic             r_frame_tick;
  logic             w_adv;
  logic             w_wrap;

  // Advance is taken from the divider itself so that with CLK_DIV=1 the counters
  // move on every edge after reset, even though the registered strobe starts at 0.
  always_comb begin
    w_adv     = (r_div == DIV_LAST);
    w_div_nxt = w_adv ? '0 : r_div + 1'b1;
    w_h_nxt   = r_h;
    w_v_nxt   = r_v;
    w_wrap    = 1'b0;
    if (w_adv) begin
      if (r_h == H_LAST) begin
        w_h_nxt = '0;
        w_v_nxt = (r_v == V_LAST) ? '0 : r_v + 10'd1;
        w_wrap  = (r_v == V_LAST);
      end else begin
        w_h_nxt = r_h + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_div        <= '0;
      r_h          <= '0;
      r_v          <= '0;
      r_hsync      <= 1'b0;
      r_vsync      <= 1'b0;
      r_bright     <= 1'b0;
      r_pix_en     <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_div        <= w_div_nxt;
      r_h          <= w_h_nxt;
      r_v          <= w_v_nxt;
      r_pix_en     <= (w_div_nxt == DIV_LAST);
      r_frame_tick <= w_wrap;
      r_hsync      <= ~(w_h_nxt < H_SW);
      r_vsync      <= ~(w_v_nxt < V_SW);
      r_bright     <= (w_h_nxt >= H_VS) && (w_h_nxt < H_VE) &&
                      (w_v_nxt >= V_VS) && (w_v_nxt < V_VE);
    end
  end

  assign o_vga.hCount     = r_h;
  assign o_vga.vCount     = r_v;
  assign o_vga.bright     = r_bright;
  assign o_vga.hSync      = r_hsync;
  assign o_vga.vSync      = r_vsync;
  assign o_vga.pix_en     = r_pix_en;
  assign o_vga.frame_tick = r_frame_tick;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size 640x480 timing for line-level checks, plus a scaled CLK_DIV=1 raster
// (20x10 lines, 12x5 visible) so whole frames fit in a short run.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if vif_a ();
  vga_timing_gen_if vif_b ();

  vga_timing_gen u_dut (
    .clk     (clk),
    .reset_n (rst_a_n),
    .o_vga   (vif_a)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_TOTAL(20), .H_SYNC(3), .H_VIS_START(5), .H_VIS_END(17),
    .V_TOTAL(10), .V_SYNC(2), .V_VIS_START(3), .V_VIS_END(8)
  ) u_small (
    .clk     (clk),
    .reset_n (rst_b_n),
    .o_vga   (vif_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 1000; i++) tick();
    rst_a_n = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    if (vif_a.hCount !== 10'd0) $display("FAIL rst_hcount got %0d want 0", vif_a.hCount); else n_pass++;
    n_total++;
    if (vif_a.vCount !== 10'd0) $display("FAIL rst_vcount got %0d want 0", vif_a.vCount); else n_pass++;
    n_total++;
    if ({vif_a.bright, vif_a.hSync, vif_a.vSync, vif_a.pix_en, vif_a.frame_tick} !== 5'b0)
      $display("FAIL rst_flags got %b want 00000",
               {vif_a.bright, vif_a.hSync, vif_a.vSync, vif_a.pix_en, vif_a.frame_tick});
    else n_pass++;
    n_total++;
    rst_a_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    if (vif_a.pix_en !== 1'b1 || vif_a.hCount !== 10'd0)
      $display("FAIL rst_pix_en3 got pix_en=%b h=%0d want 1/0", vif_a.pix_en, vif_a.hCount);
    else n_pass++;
    n_total++;
    tick();
    if (vif_a.hCount !== 10'd1 || vif_a.pix_en !== 1'b0)
      $display("FAIL rst_h_after4 got h=%0d pix_en=%b want 1/0", vif_a.hCount, vif_a.pix_en);
    else n_pass++;
    n_total++;
    for (int i = 0; i < 4; i++) tick();
    if (vif_a.hCount !== 10'd2) $display("FAIL rst_h_after8 got %0d want 2", vif_a.hCount); else n_pass++;
    n_total++;
  endtask

  task automatic test_hsync();
    int n_low = 0;
    int n_high = 0;
    int bright_seen = 0;
    rst_a_n = 1'b0;
    tick();
    rst_a_n = 1'b1;
    while (vif_a.hSync === 1'b0 && n_low < 5000) begin
      tick();
      n_low++;
      if (vif_a.bright !== 1'b0) bright_seen++;
    end
    if (n_low !== 384) $display("FAIL hsync_low_clk got %0d want 384", n_low); else n_pass++;
    n_total++;
    if (vif_a.hCount !== 10'd96) $display("FAIL hsync_rise_h got %0d want 96", vif_a.hCount); else n_pass++;
    n_total++;
    while (vif_a.hSync === 1'b1 && n_high < 5000) begin
      tick();
      n_high++;
      if (vif_a.bright !== 1'b0 && vif_a.vCount == 10'd0) bright_seen++;
    end
    if (n_low + n_high !== 3200) $display("FAIL line_period got %0d want 3200", n_low + n_high); else n_pass++;
    n_total++;
    if (vif_a.hCount !== 10'd0 || vif_a.vCount !== 10'd1)
      $display("FAIL hsync_fall_pos got (%0d,%0d) want (0,1)", vif_a.hCount, vif_a.vCount);
    else n_pass++;
    n_total++;
    if (bright_seen !== 0) $display("FAIL line0_bright got %0d want 0", bright_seen); else n_pass++;
    n_total++;
  endtask

  task automatic test_clkdiv1();
    rst_b_n = 1'b0;
    tick();
    rst_b_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (vif_b.pix_en !== 1'b1 || vif_b.hCount !== 10'(k))
        $display("FAIL div1_step%0d got pix_en=%b h=%0d want 1/%0d", k, vif_b.pix_en, vif_b.hCount, k);
      else n_pass++;
      n_total++;
    end
  endtask

  task automatic test_frame();
    int n = 0;
    int n_bright = 0;
    int n_vlow = 0;
    int n_hlow = 0;
    int first_h = -1;
    int first_v = -1;
    logic edge_bright = 1'b1;
    rst_b_n = 1'b0;
    tick();
    rst_b_n = 1'b1;
    while (vif_b.frame_tick !== 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    if (n !== 200) $display("FAIL first_tick_clk got %0d want 200", n); else n_pass++;
    n_total++;
    if (vif_b.hCount !== 10'd0 || vif_b.vCount !== 10'd0)
      $display("FAIL tick_pos got (%0d,%0d) want (0,0)", vif_b.hCount, vif_b.vCount);
    else n_pass++;
    n_total++;
    for (int i = 0; i < 200; i++) begin
      if (vif_b.bright === 1'b1) begin
        n_bright++;
        if (first_h < 0) begin
          first_h = int'(vif_b.hCount);
          first_v = int'(vif_b.vCount);
        end
      end
      if (vif_b.vSync === 1'b0) n_vlow++;
      if (vif_b.hSync === 1'b0) n_hlow++;
      if ((vif_b.hCount == 10'd17 && vif_b.vCount == 10'd3) ||
          (vif_b.hCount == 10'd5 && vif_b.vCount == 10'd8))
        edge_bright = edge_bright & ~vif_b.bright;
      if (i > 0 && vif_b.frame_tick !== 1'b0) n_bright = n_bright + 1000;
      tick();
    end
    if (vif_b.frame_tick !== 1'b1) $display("FAIL tick_spacing got %b at +200 want 1", vif_b.frame_tick); else n_pass++;
    n_total++;
    if (n_bright !== 60) $display("FAIL bright_count got %0d want 60", n_bright); else n_pass++;
    n_total++;
    if (first_h !== 5 || first_v !== 3)
      $display("FAIL first_bright got (%0d,%0d) want (5,3)", first_h, first_v);
    else n_pass++;
    n_total++;
    if (edge_bright !== 1'b1) $display("FAIL bright_edges got %b want 1", edge_bright); else n_pass++;
    n_total++;
    if (n_vlow !== 40) $display("FAIL vsync_low got %0d want 40", n_vlow); else n_pass++;
    n_total++;
    if (n_hlow !== 30) $display("FAIL hsync_low_frame got %0d want 30", n_hlow); else n_pass++;
    n_total++;
  endtask

  task automatic test_midframe_reset();
    int n = 0;
    while (!(vif_b.hCount == 10'd10 && vif_b.vCount == 10'd6) && n < 1000) begin
      tick();
      n++;
    end
    if (n >= 1000) $display("FAIL mid_reach got timeout want (10,6)"); else n_pass++;
    n_total++;
    rst_b_n = 1'b0;
    tick();
    if ({vif_b.hCount, vif_b.vCount} !== 20'd0 || vif_b.hSync !== 1'b0 || vif_b.vSync !== 1'b0 ||
        vif_b.frame_tick !== 1'b0)
      $display("FAIL mid_reset got (%0d,%0d) hs=%b vs=%b ft=%b want (0,0) 0 0 0",
               vif_b.hCount, vif_b.vCount, vif_b.hSync, vif_b.vSync, vif_b.frame_tick);
    else n_pass++;
    n_total++;
    rst_b_n = 1'b1;
    n = 0;
    while (vif_b.frame_tick !== 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    if (n !== 200) $display("FAIL mid_next_tick got %0d want 200", n); else n_pass++;
    n_total++;
  endtask

  initial begin
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    tick();
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    test_reset();
    test_hsync();
    test_clkdiv1();
    test_frame();
    test_midframe_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
